// File: rtl/pll_lock_monitor.sv
// PLL lock monitor: synchronizes the PLL locked flag, qualifies it for a number of
// stable cycles, holds downstream reset for a while, then tracks lock losses.
module pll_lock_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int RESET_HOLD    = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             locked,
    input  logic             clear_status,
    output logic             rst_out,
    output logic             ready,
    output logic             lost_lock,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int STABLE_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int HOLD_W   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        QUALIFY,
        HOLD,
        RUN
    } state_t;

    state_t               state, state_next;
    logic [STABLE_W-1:0]  stable_cnt, stable_next;
    logic [HOLD_W-1:0]    hold_cnt, hold_next;
    logic                 lost_next;
    logic [CNT_W-1:0]     count_next;
    logic [CNT_W-1:0]     count_base;
    logic                 loss_event;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 locked_s;

    // locked is asynchronous to clock; only the last stage is ever looked at
    always_ff @(posedge clock) begin
        if (reset)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next  = state;
        stable_next = stable_cnt;
        hold_next   = hold_cnt;
        loss_event  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next  = QUALIFY;
                    stable_next = '0;
                end
            end
            QUALIFY: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end else begin
                    stable_next = stable_cnt + STABLE_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s)
                    state_next = WAIT_LOCK;
                else if (hold_cnt == HOLD_LAST)
                    state_next = RUN;
                else
                    hold_next = hold_cnt + HOLD_W'(1);
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: state_next = WAIT_LOCK;
        endcase

        // A loss on the same edge as a clear wins, counting from the cleared value
        count_base = clear_status ? '0 : lock_loss_count;
        lost_next  = clear_status ? 1'b0 : lost_lock;
        count_next = count_base;
        if (loss_event) begin
            lost_next = 1'b1;
            if (count_base != {CNT_W{1'b1}})
                count_next = count_base + CNT_W'(1);
        end
    end

    // Outputs are registered from the next state so they move with the state change
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= WAIT_LOCK;
            stable_cnt      <= '0;
            hold_cnt        <= '0;
            rst_out         <= 1'b1;
            ready           <= 1'b0;
            lost_lock       <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state           <= state_next;
            stable_cnt      <= stable_next;
            hold_cnt        <= hold_next;
            rst_out         <= (state_next != RUN);
            ready           <= (state_next == RUN);
            lost_lock       <= lost_next;
            lock_loss_count <= count_next;
        end
    end

endmodule
